// File: rtl/div_pkg.sv
// Shared definitions for the sequential 64/32 restoring divider: datapath width,
// counter width and FSM state encoding.
package div_pkg;

  localparam int N     = 32;
  localparam int CNT_W = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : div_pkg

// File: rtl/seq_divider64by32_if.sv
// Operand and result handshakes of the divider. The DUT takes the slave side and the
// producer/consumer takes the master side.
interface seq_divider64by32_if #(
  parameter int N = div_pkg::N
);

  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   dividend;
  logic [N-1:0]     divisor;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     quotient;
  logic [N-1:0]     remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

endinterface : seq_divider64by32_if

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, then trial-subtract
// the divisor and keep the difference only when no borrow occurs.
module div_step #(
  parameter int N = div_pkg::N
) (
  input  logic [N:0]   r,
  input  logic         q_msb,
  input  logic [N-1:0] divisor,
  output logic [N:0]   r_next,
  output logic         q_bit
);

  logic [N:0]   shifted;
  logic [N+1:0] diff;
  // The partial remainder stays below the divisor, so its top bit never carries information.
  logic         unused_r_msb;

  assign unused_r_msb = r[N];

  always_comb begin
    shifted = {r[N-1:0], q_msb};
    diff    = {1'b0, shifted} - {2'b00, divisor};
    q_bit   = ~diff[N+1];
    r_next  = q_bit ? diff[N:0] : shifted;
  end

endmodule : div_step

// File: rtl/seq_divider64by32.sv
// Sequential unsigned 2N/N restoring divider that produces one quotient bit per cycle.
// Exceptional operands go straight to DONE without running the iteration loop.
import div_pkg::*;

module seq_divider64by32 (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_divider64by32_if.slave   bus
);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [N:0]       r_reg;
  logic [N-1:0]     q_reg;
  logic [N-1:0]     divisor_reg;
  logic [N-1:0]     quotient_reg;
  logic [N-1:0]     remainder_reg;
  logic             ready_reg;
  logic             out_valid_reg;
  logic             dbz_reg;
  logic             ovf_reg;

  logic [N:0]       r_step;
  logic             q_bit;
  logic [N-1:0]     q_shift;

  div_step #(.N(N)) u_step (
    .r       (r_reg),
    .q_msb   (q_reg[N-1]),
    .divisor (divisor_reg),
    .r_next  (r_step),
    .q_bit   (q_bit)
  );

  assign q_shift         = {q_reg[N-2:0], q_bit};
  assign bus.in_ready    = ready_reg;
  assign bus.out_valid   = out_valid_reg;
  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.div_by_zero = dbz_reg;
  assign bus.overflow    = ovf_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      r_reg         <= '0;
      q_reg         <= '0;
      divisor_reg   <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      ready_reg     <= 1'b0;
      out_valid_reg <= 1'b0;
      dbz_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          ready_reg <= 1'b1;
          // ready_reg gates acceptance so the first cycle after reset cannot take a job.
          if (bus.in_valid && ready_reg) begin
            ready_reg   <= 1'b0;
            divisor_reg <= bus.divisor;
            cnt_reg     <= '0;
            if (bus.divisor == '0) begin
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
              dbz_reg       <= 1'b1;
              quotient_reg  <= '1;
              remainder_reg <= bus.dividend[N-1:0];
            end else if (bus.dividend[2*N-1:N] >= bus.divisor) begin
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
              ovf_reg       <= 1'b1;
              quotient_reg  <= '1;
              remainder_reg <= '0;
            end else begin
              state_reg <= RUN;
              r_reg     <= {1'b0, bus.dividend[2*N-1:N]};
              q_reg     <= bus.dividend[N-1:0];
            end
          end
        end

        RUN: begin
          r_reg   <= r_step;
          q_reg   <= q_shift;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(N - 1)) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
            quotient_reg  <= q_shift;
            remainder_reg <= r_step[N-1:0];
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            dbz_reg       <= 1'b0;
            ovf_reg       <= 1'b0;
            ready_reg     <= 1'b1;
          end
        end

        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          ready_reg     <= 1'b0;
        end
      endcase
    end
  end

endmodule : seq_divider64by32

// File: tb/tb_seq_divider64by32.sv
// Self-checking bench for seq_divider64by32: directed corner cases, stall, mid-run reset,
// back-to-back throughput and randomized jobs against an arithmetic reference model.
module tb_seq_divider64by32;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;

  seq_divider64by32_if bus ();

  seq_divider64by32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: quotient and remainder from plain 64-bit arithmetic.
  function automatic void model(input logic [63:0] dvd, input logic [31:0] dvs,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dbz, output logic ovf, output int lat);
    logic [63:0] tmp;
    dbz = 1'b0;
    ovf = 1'b0;
    if (dvs == 32'd0) begin
      dbz = 1'b1; q = 32'hFFFF_FFFF; r = dvd[31:0]; lat = 1;
    end else if (dvd[63:32] >= dvs) begin
      ovf = 1'b1; q = 32'hFFFF_FFFF; r = 32'd0; lat = 1;
    end else begin
      tmp = dvd / {32'd0, dvs}; q = tmp[31:0];
      tmp = dvd % {32'd0, dvs}; r = tmp[31:0];
      lat = 33;
    end
  endfunction

  // Drives one job and collects the result; lat counts edges from the accepting edge inclusive.
  task automatic do_job(input logic [63:0] dvd, input logic [31:0] dvs, input int stall,
                        output logic [31:0] q, output logic [31:0] r,
                        output logic dbz, output logic ovf, output int lat, output int acc);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    bus.in_valid = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk); #1;
    acc = cyc;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    q   = bus.quotient;
    r   = bus.remainder;
    dbz = bus.div_by_zero;
    ovf = bus.overflow;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.dividend = '0;   bus.divisor = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.quotient !== 32'd0) begin bad++; $display("FAIL reset_quotient got=%h want=0", bus.quotient); end
    total++; if (bus.remainder !== 32'd0) begin bad++; $display("FAIL reset_remainder got=%h want=0", bus.remainder); end
    total++; if ({bus.div_by_zero, bus.overflow} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b%b want=00", bus.div_by_zero, bus.overflow); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", bus.in_ready); end
  endtask

  task automatic test_directed();
    logic [63:0] t_dvd [4];
    logic [31:0] t_dvs [4];
    logic [31:0] t_q   [4];
    logic [31:0] t_r   [4];
    logic [1:0]  t_fl  [4];
    int          t_lat [4];
    logic [31:0] q, r;
    logic        dbz, ovf;
    int          lat, acc;
    t_dvd = '{64'd100, 64'hFFFF_FFFE_0000_0001, 64'h0000_0000_1234_5678, 64'h0000_0005_0000_0000};
    t_dvs = '{32'd7, 32'hFFFF_FFFF, 32'd0, 32'd5};
    t_q   = '{32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    t_r   = '{32'd2, 32'd0, 32'h1234_5678, 32'd0};
    t_fl  = '{2'b00, 2'b00, 2'b10, 2'b01};
    t_lat = '{33, 33, 1, 1};
    for (int i = 0; i < 4; i++) begin
      do_job(t_dvd[i], t_dvs[i], 0, q, r, dbz, ovf, lat, acc);
      total++; if (q !== t_q[i]) begin bad++; $display("FAIL dir%0d_quotient got=%h want=%h", i, q, t_q[i]); end
      total++; if (r !== t_r[i]) begin bad++; $display("FAIL dir%0d_remainder got=%h want=%h", i, r, t_r[i]); end
      total++; if ({dbz, ovf} !== t_fl[i]) begin bad++; $display("FAIL dir%0d_flags got=%b%b want=%b", i, dbz, ovf, t_fl[i]); end
      total++; if (lat !== t_lat[i]) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, t_lat[i]); end
      $display("dir%0d %h / %h -> q=%h r=%h dbz=%b ovf=%b lat=%0d", i, t_dvd[i], t_dvs[i], q, r, dbz, ovf, lat);
    end
  endtask

  task automatic test_stall();
    int lat;
    int quiet_bad;
    bus.in_valid = 1'b1; bus.dividend = 64'd1000; bus.divisor = 32'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    total++; if (lat !== 33) begin bad++; $display("FAIL stall_latency got=%0d want=33", lat); end
    // Second operand set offered while the result is stalled must be ignored.
    bus.in_valid = 1'b1; bus.dividend = 64'd50; bus.divisor = 32'd5;
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.out_valid !== 1'b1 || bus.quotient !== 32'd333 || bus.remainder !== 32'd1)
        begin bad++; $display("FAIL stall%0d_hold got v=%b q=%0d r=%0d want v=1 q=333 r=1", i, bus.out_valid, bus.quotient, bus.remainder); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall%0d_in_ready got=%b want=0", i, bus.in_ready); end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      begin bad++; $display("FAIL stall_release got ready=%b valid=%b want ready=1 valid=0", bus.in_ready, bus.out_valid); end
    quiet_bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) quiet_bad++;
    end
    total++; if (quiet_bad !== 0) begin bad++; $display("FAIL stall_no_accept got=%0d busy cycles want=0", quiet_bad); end
    $display("stall 1000/3 held 5 cycles, second operand set ignored");
  endtask

  task automatic test_reset_midrun();
    int seen;
    logic [31:0] q, r;
    logic        dbz, ovf;
    int          lat, acc;
    bus.in_valid = 1'b1; bus.dividend = 64'h0000_0001_0000_0000; bus.divisor = 32'd2;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++; if (bus.out_valid !== 1'b0 || bus.quotient !== 32'd0 || bus.remainder !== 32'd0 || bus.in_ready !== 1'b0)
      begin bad++; $display("FAIL midrun_reset_outputs got v=%b q=%h r=%h rdy=%b want all 0", bus.out_valid, bus.quotient, bus.remainder, bus.in_ready); end
    @(posedge clk); #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL midrun_in_ready got=%b want=1", bus.in_ready); end
    seen = 0;
    repeat (40) begin
      if (bus.out_valid !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midrun_no_result got=%0d valid cycles want=0", seen); end
    do_job(64'h0000_0001_0000_0000, 32'd2, 0, q, r, dbz, ovf, lat, acc);
    total++; if (q !== 32'h8000_0000 || r !== 32'd0) begin bad++; $display("FAIL midrun_rerun got q=%h r=%h want q=80000000 r=0", q, r); end
    $display("midrun reset aborted job, rerun q=%h r=%h", q, r);
  endtask

  task automatic test_back_to_back();
    logic [63:0] dvd;
    logic [31:0] dvs, q, r, eq, er;
    logic        dbz, ovf, edbz, eovf;
    int          lat, elat, acc, prev_acc;
    prev_acc = 0;
    for (int i = 0; i < 3; i++) begin
      dvs = $urandom | 32'd1;
      dvd = {($urandom % dvs), $urandom};
      model(dvd, dvs, eq, er, edbz, eovf, elat);
      do_job(dvd, dvs, 0, q, r, dbz, ovf, lat, acc);
      total++; if (q !== eq || r !== er) begin bad++; $display("FAIL b2b%0d_result got q=%h r=%h want q=%h r=%h", i, q, r, eq, er); end
      if (i > 0) begin
        total++; if (acc - prev_acc !== 34) begin bad++; $display("FAIL b2b%0d_spacing got=%0d want=34", i, acc - prev_acc); end
      end
      $display("b2b%0d %h / %h -> q=%h r=%h accepted at cycle %0d", i, dvd, dvs, q, r, acc);
      prev_acc = acc;
    end
  endtask

  task automatic test_random();
    logic [63:0] dvd;
    logic [31:0] dvs, hi, q, r, eq, er;
    logic        dbz, ovf, edbz, eovf;
    int          lat, elat, acc, mode;
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 9);
      case (mode)
        0: begin dvs = 32'd0; hi = $urandom; end
        1: begin dvs = $urandom_range(32'h7FFF_FFFF, 1); hi = dvs + $urandom_range(100, 0); end
        2: begin dvs = $urandom_range(15, 1); hi = $urandom_range(dvs - 1, 0); end
        default: begin dvs = $urandom | 32'd1; hi = $urandom_range(dvs - 1, 0); end
      endcase
      dvd = {hi, $urandom};
      model(dvd, dvs, eq, er, edbz, eovf, elat);
      do_job(dvd, dvs, $urandom_range(3, 0), q, r, dbz, ovf, lat, acc);
      total++; if (q !== eq) begin bad++; $display("FAIL rnd%0d_quotient got=%h want=%h", i, q, eq); end
      total++; if (r !== er) begin bad++; $display("FAIL rnd%0d_remainder got=%h want=%h", i, r, er); end
      total++; if ({dbz, ovf} !== {edbz, eovf}) begin bad++; $display("FAIL rnd%0d_flags got=%b%b want=%b%b", i, dbz, ovf, edbz, eovf); end
      total++; if (lat !== elat) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, lat, elat); end
      $display("rnd%0d %h / %h -> q=%h r=%h dbz=%b ovf=%b lat=%0d", i, dvd, dvs, q, r, dbz, ovf, lat);
    end
  endtask

  initial begin
    cyc   = 0;
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_stall();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seq_divider64by32
